// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the write-back stage: write-data select encodings,
// the hardwired-zero register index and the FSM state type.
package writeback_stage_pkg;

    localparam logic [1:0] WDSEL_PC4 = 2'd0;
    localparam logic [1:0] WDSEL_ALU = 2'd1;
    localparam logic [1:0] WDSEL_MEM = 2'd2;

    localparam int REG_ZERO = 31;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_wd_select_mux.sv
// Combinational 4:1 write-data select; both encodings 1 and 3 pick the ALU result.
module wd_select_mux
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        wdsel_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] wd_o
);

    always_comb begin
        wd_o = alu_i;
        case (wdsel_i)
            WDSEL_PC4: wd_o = pc4_i;
            WDSEL_MEM: wd_o = mem_rdata_i;
            default:   wd_o = alu_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: selects write data, waits for load data when needed and
// drives registered single-cycle register-file write pulses; counts retirements.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [REG_AW-1:0] rc_i,
    input  logic              werf_i,
    input  logic [1:0]        wdsel_i,
    input  logic [DATA_W-1:0] pc4_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [REG_AW-1:0] rc_o,
    output logic              werf_o,
    output logic [DATA_W-1:0] wd_o,
    output logic [31:0]       retired_o
);

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

    wb_state_e         r_state;
    wb_state_e         w_nextState;
    logic [REG_AW-1:0] r_loadRc;
    logic [REG_AW-1:0] r_rc;
    logic [DATA_W-1:0] r_wd;
    logic              r_werf;
    logic [31:0]       r_retired;

    logic [DATA_W-1:0] w_selData;
    logic              w_isLoad;
    logic              w_latchLoad;
    logic              w_retire;
    logic              w_wrReq;
    logic              w_wrEff;
    logic [REG_AW-1:0] w_wrIdx;
    logic [DATA_W-1:0] w_wrData;

    wd_select_mux #(
        .DATA_W (DATA_W)
    ) u_wd_select_mux (
        .wdsel_i     (wdsel_i),
        .pc4_i       (pc4_i),
        .alu_i       (alu_i),
        .mem_rdata_i (mem_rdata_i),
        .wd_o        (w_selData)
    );

    // Only writing loads wait; stores and non-linking branches retire at once.
    assign w_isLoad = werf_i && (wdsel_i == WDSEL_MEM);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        ready_o     = 1'b0;
        w_latchLoad = 1'b0;
        w_retire    = 1'b0;
        w_wrReq     = 1'b0;
        w_wrIdx     = rc_i;
        w_wrData    = w_selData;
        case (r_state)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    if (w_isLoad) begin
                        w_latchLoad = 1'b1;
                        w_nextState = ST_WAIT_MEM;
                    end else begin
                        w_retire = 1'b1;
                        w_wrReq  = werf_i;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid_i) begin
                    w_retire    = 1'b1;
                    w_wrReq     = 1'b1;
                    w_wrIdx     = r_loadRc;
                    w_wrData    = mem_rdata_i;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // R31 reads as zero, so writes to it are suppressed but still retire.
    assign w_wrEff = w_wrReq && (w_wrIdx != ZERO_IDX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_loadRc  <= '0;
            r_rc      <= '0;
            r_wd      <= '0;
            r_werf    <= 1'b0;
            r_retired <= '0;
        end else begin
            r_werf <= w_wrEff;
            if (w_latchLoad) begin
                r_loadRc <= rc_i;
            end
            if (w_wrEff) begin
                r_rc <= w_wrIdx;
                r_wd <= w_wrData;
            end
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign rc_o      = r_rc;
    assign wd_o      = r_wd;
    assign werf_o    = r_werf;
    assign retired_o = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table followed by
// randomized traffic compared against a behavioural model.
module tb_writeback_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              valid_i;
    logic              ready_o;
    logic [REG_AW-1:0] rc_i;
    logic              werf_i;
    logic [1:0]        wdsel_i;
    logic [DATA_W-1:0] pc4_i;
    logic [DATA_W-1:0] alu_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [REG_AW-1:0] rc_o;
    logic              werf_o;
    logic [DATA_W-1:0] wd_o;
    logic [31:0]       retired_o;

    int checks   = 0;
    int failures = 0;

    writeback_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .rc_i         (rc_i),
        .werf_i       (werf_i),
        .wdsel_i      (wdsel_i),
        .pc4_i        (pc4_i),
        .alu_i        (alu_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rc_o         (rc_o),
        .werf_o       (werf_o),
        .wd_o         (wd_o),
        .retired_o    (retired_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  rc;
        logic        werf;
        logic [1:0]  wdsel;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic        rvalid;
        logic [31:0] rdata;
        logic        chkReady;
        logic        expReady;
        logic        expWerf;
        logic [4:0]  expRc;
        logic [31:0] expWd;
        logic [31:0] expRet;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: one pending load at most, outputs as plain variables.
    bit          mWaiting;
    logic [4:0]  mPendRc;
    logic        mWerf;
    logic [4:0]  mRc;
    logic [31:0] mWd;
    logic [31:0] mRet;

    function automatic vec_t mk(logic rst, logic valid, logic [4:0] rc, logic werf,
                                logic [1:0] wdsel, logic [31:0] pc4, logic [31:0] alu,
                                logic rvalid, logic [31:0] rdata, logic chkReady,
                                logic expReady, logic expWerf, logic [4:0] expRc,
                                logic [31:0] expWd, logic [31:0] expRet);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rc = rc; v.werf = werf; v.wdsel = wdsel;
        v.pc4 = pc4; v.alu = alu; v.rvalid = rvalid; v.rdata = rdata;
        v.chkReady = chkReady; v.expReady = expReady; v.expWerf = expWerf;
        v.expRc = expRc; v.expWd = expWd; v.expRet = expRet;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_i        = v.rst;
        valid_i      = v.valid;
        rc_i         = v.rc;
        werf_i       = v.werf;
        wdsel_i      = v.wdsel;
        pc4_i        = v.pc4;
        alu_i        = v.alu;
        mem_rvalid_i = v.rvalid;
        mem_rdata_i  = v.rdata;
    endtask

    task automatic modelStep();
        logic [31:0] data;
        if (rst_i) begin
            mWaiting = 0; mPendRc = '0; mWerf = 0; mRc = '0; mWd = '0; mRet = '0;
        end else begin
            mWerf = 0;
            if (!mWaiting) begin
                if (valid_i) begin
                    if (werf_i && wdsel_i == 2'd2) begin
                        mWaiting = 1;
                        mPendRc  = rc_i;
                    end else begin
                        data = (wdsel_i == 2'd0) ? pc4_i : (wdsel_i == 2'd2) ? mem_rdata_i : alu_i;
                        mRet = mRet + 1;
                        if (werf_i && rc_i != 5'd31) begin
                            mWerf = 1; mRc = rc_i; mWd = data;
                        end
                    end
                end
            end else if (mem_rvalid_i) begin
                mWaiting = 0;
                mRet     = mRet + 1;
                if (mPendRc != 5'd31) begin
                    mWerf = 1; mRc = mPendRc; mWd = mem_rdata_i;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic expWerf, input logic [4:0] expRc,
                               input logic [31:0] expWd, input logic [31:0] expRet);
        check({tag, " werf_o"}, 32'(werf_o), 32'(expWerf));
        check({tag, " rc_o"}, 32'(rc_o), 32'(expRc));
        check({tag, " wd_o"}, wd_o, expWd);
        check({tag, " retired_o"}, retired_o, expRet);
    endtask

    initial begin
        //      rst valid rc  werf sel pc4        alu           rv rdata        chk rdy werf rc  wd            ret
        vecs.push_back(mk(1, 0, 0,  0, 0, 0,         0,            0, 0,            0, 0, 0, 0,  0,            0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 1, 0, 0,  0,            0));
        vecs.push_back(mk(0, 1, 1,  1, 1, 0,         32'h11,       0, 0,            1, 1, 1, 1,  32'h11,       1));
        vecs.push_back(mk(0, 1, 2,  1, 1, 0,         32'h22,       0, 0,            1, 1, 1, 2,  32'h22,       2));
        vecs.push_back(mk(0, 1, 3,  1, 1, 0,         32'h33,       0, 0,            1, 1, 1, 3,  32'h33,       3));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 1, 0, 3,  32'h33,       3));
        vecs.push_back(mk(0, 1, 28, 1, 0, 32'h104,   32'hDEAD,     0, 0,            1, 1, 1, 28, 32'h104,      4));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            1, 32'h999,      1, 1, 0, 28, 32'h104,      4));
        vecs.push_back(mk(0, 1, 5,  1, 2, 0,         32'h55,       0, 0,            1, 1, 0, 28, 32'h104,      4));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 0, 0, 28, 32'h104,      4));
        vecs.push_back(mk(0, 1, 7,  1, 1, 0,         32'h77,       0, 0,            1, 0, 0, 28, 32'h104,      4));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 0, 0, 28, 32'h104,      4));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 0, 0, 28, 32'h104,      4));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            1, 32'hCAFEF00D, 1, 0, 1, 5,  32'hCAFEF00D, 5));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 1, 0, 5,  32'hCAFEF00D, 5));
        vecs.push_back(mk(0, 1, 31, 1, 1, 0,         32'h3131,     0, 0,            1, 1, 0, 5,  32'hCAFEF00D, 6));
        vecs.push_back(mk(0, 1, 9,  0, 2, 0,         32'h99,       0, 0,            1, 1, 0, 5,  32'hCAFEF00D, 7));
        vecs.push_back(mk(0, 1, 10, 1, 3, 0,         32'hAAAA,     0, 0,            1, 1, 1, 10, 32'hAAAA,     8));
        vecs.push_back(mk(0, 1, 31, 1, 2, 0,         0,            0, 0,            1, 1, 0, 10, 32'hAAAA,     8));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 0, 0, 10, 32'hAAAA,     8));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            1, 32'h1234,     1, 0, 0, 10, 32'hAAAA,     9));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 1, 0, 10, 32'hAAAA,     9));
        vecs.push_back(mk(0, 1, 6,  1, 2, 0,         0,            0, 0,            1, 1, 0, 10, 32'hAAAA,     9));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 0, 0, 10, 32'hAAAA,     9));
        vecs.push_back(mk(1, 1, 12, 1, 1, 0,         32'h1212,     1, 32'hBEEF,     1, 0, 0, 0,  0,            0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            1, 32'h5555,     1, 1, 0, 0,  0,            0));
        vecs.push_back(mk(0, 1, 4,  1, 2, 0,         0,            0, 0,            1, 1, 0, 0,  0,            0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            1, 32'h4444,     1, 0, 1, 4,  32'h4444,     1));
        vecs.push_back(mk(0, 1, 8,  1, 1, 0,         32'h88,       0, 0,            1, 1, 1, 8,  32'h88,       2));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,         0,            0, 0,            1, 1, 0, 8,  32'h88,       2));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            applyStimulus(vecs[i]);
            #1;
            if (vecs[i].chkReady) begin
                check($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'(vecs[i].expReady));
            end
            modelStep();
            @(posedge clk_i);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].expWerf, vecs[i].expRc,
                        vecs[i].expWd, vecs[i].expRet);
        end

        for (int i = 0; i < 600; i++) begin
            vec_t v;
            @(negedge clk_i);
            v.rst    = ($urandom_range(0, 59) == 0);
            v.valid  = ($urandom_range(0, 9) < 6);
            v.rc     = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            v.werf   = ($urandom_range(0, 3) != 0);
            v.wdsel  = 2'($urandom_range(0, 3));
            v.pc4    = $urandom;
            v.alu    = $urandom;
            v.rvalid = ($urandom_range(0, 9) < 3);
            v.rdata  = $urandom;
            applyStimulus(v);
            #1;
            check($sformatf("rnd%0d ready_o", i), 32'(ready_o), 32'(!mWaiting));
            modelStep();
            @(posedge clk_i);
            #1;
            checkOutput($sformatf("rnd%0d", i), mWerf, mRc, mWd, mRet);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
